// File: rtl/systolic_pkg.sv
// Shared sizing, FSM encoding and saturating-count helper for the systolic feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int SYS_N  = 4;   // lanes = systolic array rows
  localparam int SYS_DW = 8;   // PE operand width
  localparam int KCNT_W = 16;  // accepted-vector counter width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [KCNT_W-1:0] sat_inc(input logic [KCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay.sv
// Depth-D, DW-wide shift register used to skew one feeder lane.
// Latency: D cycles from din_i to dout_o.
// Backpressure: none; shifts every cycle.
module skew_delay #(
  parameter int D  = 1,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] stage_q [D];

  // Shift one stage per cycle; reset empties the pipe to zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int k = 1; k < D; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign dout_o = stage_q[D-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews accepted operand vectors onto the west edge of an N-row systolic array and sequences a job.
// Latency: lane i shows a vector i+1 cycles after acceptance; done 2N-1 cycles after the last vector.
// Backpressure: in_ready high only while streaming; idle cycles inject zero bubbles into every lane.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int DW = SYS_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_data,
  input  logic              in_last,
  output logic [N*DW-1:0]   feed_data,
  output logic              pe_clr,
  output logic              busy,
  output logic              done,
  output logic [KCNT_W-1:0] k_count
);

  localparam int FC_W = (2 * N > 2) ? $clog2(2 * N) : 1;
  // FLUSH lasts 2N-1 cycles: counter runs 0 .. 2N-2.
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(2 * N - 2);

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [KCNT_W-1:0] k_q, k_d;
  logic              accept;
  logic [N*DW-1:0]   lane_in;

  assign accept   = in_valid && (state_q == ST_STREAM);
  // Bubbles and non-stream cycles push zeros so lanes stay aligned and add zero products.
  assign lane_in  = accept ? in_data : '0;

  assign in_ready = (state_q == ST_STREAM);
  assign pe_clr   = (state_q == ST_CLR);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign k_count  = k_q;

  // State, flush counter and job vector count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      k_q         <= k_d;
    end
  end

  // Next-state logic: start only seen in IDLE, in_last only seen with an accepted vector.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    k_d         = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLR;
      end
      ST_CLR: begin
        k_d     = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          k_d = sat_inc(k_q);
          if (in_last) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_DONE;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane i gets i+1 register stages so the array sees a diagonal wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(
      .D  (i + 1),
      .DW (DW)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst),
      .din_i  (lane_in[i*DW +: DW]),
      .dout_o (feed_data[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench: job-level reference model plus a behavioural 4x4 PE array for matmul checks.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;
  localparam int OW = W + 20;
  localparam int P_IDLE = 0, P_CLR = 1, P_STREAM = 2, P_FLUSH = 3, P_DONE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] b_vec = '0;
  logic         in_ready, pe_clr, busy, done;
  logic [W-1:0] feed_data;
  logic [15:0]  k_count;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase, flush cycle count, vector count, last N lane inputs (newest first).
  int           ph = P_IDLE;
  int           fcyc = 0;
  logic [15:0]  mk = '0;
  logic [W-1:0] hist [$];
  logic [W-1:0] a_list [$];
  logic [W-1:0] b_list [$];
  logic [OW-1:0] expv = '0;

  wire [OW-1:0] obs = {feed_data, in_ready, pe_clr, busy, done, k_count};

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feed_data (feed_data),
    .pe_clr    (pe_clr),
    .busy      (busy),
    .done      (done),
    .k_count   (k_count)
  );

  // Output-stationary PE array: A from the DUT on the west, B skewed here on the north.
  logic [DW-1:0] bsk  [N][N] = '{default: '0};
  logic [DW-1:0] a_r  [N][N] = '{default: '0};
  logic [DW-1:0] b_r  [N][N] = '{default: '0};
  logic [31:0]   pacc [N][N] = '{default: '0};

  always @(posedge clk) begin : pe_array
    logic [DW-1:0] aw, bn;
    for (int c = 0; c < N; c++) begin
      bsk[c][0] <= (in_valid && in_ready) ? b_vec[c*DW +: DW] : '0;
      for (int d = 1; d < N; d++) bsk[c][d] <= bsk[c][d-1];
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        aw = (c == 0) ? feed_data[r*DW +: DW] : a_r[r][c-1];
        bn = (r == 0) ? bsk[c][c] : b_r[r-1][c];
        a_r[r][c]  <= aw;
        b_r[r][c]  <= bn;
        pacc[r][c] <= pe_clr ? 32'd0 : pacc[r][c] + 32'(aw) * 32'(bn);
      end
    end
  end

  function automatic logic [OW-1:0] model_obs();
    logic [W-1:0] f;
    logic [W-1:0] h;
    f = '0;
    for (int i = 0; i < N; i++) begin
      h = hist[i];
      f[i*DW +: DW] = h[i*DW +: DW];
    end
    return {f, ph == P_STREAM, ph == P_CLR, ph != P_IDLE, ph == P_DONE, mk};
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    fcyc = 0;
    mk = '0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back('0);
  endtask

  // Advance one clock: model follows the job rules, expv is refreshed 1 ns after the edge.
  task automatic tick();
    logic         acc;
    logic [W-1:0] v;
    acc = (ph == P_STREAM) && in_valid;
    v = acc ? in_data : '0;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (acc) begin
        a_list.push_back(in_data);
        b_list.push_back(b_vec);
      end
      hist.push_front(v);
      void'(hist.pop_back());
      case (ph)
        P_IDLE: if (start) ph = P_CLR;
        P_CLR: begin
          mk = '0;
          a_list.delete();
          b_list.delete();
          ph = P_STREAM;
        end
        P_STREAM: begin
          if (acc && mk != 16'hFFFF) mk = mk + 16'd1;
          if (acc && in_last) begin
            ph = P_FLUSH;
            fcyc = 1;
          end
        end
        P_FLUSH: begin
          if (fcyc == 2 * N - 1) ph = P_DONE;
          else fcyc++;
        end
        default: ph = P_IDLE;
      endcase
    end
    #1;
    expv = model_obs();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    expv = model_obs();
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_zero got=%h exp=0", obs); end
    start = 1'b1;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs, expv); end
    start = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_single_job();
    int lat = 0;
    start = 1'b1;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL sj_clr got=%h exp=%h", obs, expv); end
    start = 1'b0;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL sj_stream got=%h exp=%h", obs, expv); end
    in_valid = 1'b1;
    in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    checks++; if (feed_data[7:0] !== 8'd1) begin errors++; $display("FAIL sj_lane0 got=%0d exp=1", feed_data[7:0]); end
    in_data = {8'd8, 8'd7, 8'd6, 8'd5};
    in_last = 1'b1;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL sj_last got=%h exp=%h", obs, expv); end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL sj_flush got=%h exp=%h", obs, expv); end
      if (n == 2) begin
        checks++; if (feed_data[31:24] !== 8'd4) begin errors++; $display("FAIL sj_lane3 got=%0d exp=4", feed_data[31:24]); end
      end
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL sj_done_latency got=%0d exp=7", lat); end
    checks++; if (k_count !== 16'd2) begin errors++; $display("FAIL sj_kcount got=%0d exp=2", k_count); end
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL sj_idle got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_bubble();
    int nv = 0;
    int gap = 2;
    int lat = 0;
    logic acc;
    logic [31:0] gold;
    logic [W-1:0] av, bv;
    start = 1'b1;
    tick();
    checks++; if (obs !== expv) begin errors++; $display("FAIL bb_start got=%h exp=%h", obs, expv); end
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (nv == 4 && gap > 0 && ph == P_STREAM) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
      end
      in_data = $urandom;
      b_vec = $urandom;
      in_last = (nv == 11 && in_valid) || (!in_valid && $urandom_range(0, 1) == 1);
      acc = (ph == P_STREAM) && in_valid;
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL bb_stream got=%h exp=%h", obs, expv); end
      if (acc) nv++;
      if (acc && in_last) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL bb_flush got=%h exp=%h", obs, expv); end
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL bb_done_latency got=%0d exp=7", lat); end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        gold = 0;
        for (int k = 0; k < a_list.size(); k++) begin
          av = a_list[k];
          bv = b_list[k];
          gold = gold + 32'(av[r*DW +: DW]) * 32'(bv[c*DW +: DW]);
        end
        checks++; if (pacc[r][c] !== gold) begin errors++; $display("FAIL bb_matmul[%0d][%0d] got=%0d exp=%0d", r, c, pacc[r][c], gold); end
      end
    end
    tick();
  endtask

  task automatic test_single_vector();
    int lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sv_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1;
    in_last = 1'b1;
    in_data = 32'h09090909;
    tick();
    checks++; if (obs !== expv || in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sv_flush_entry got=%h exp=%h", obs, expv); end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL sv_flush got=%h exp=%h", obs, expv); end
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL sv_done_latency got=%0d exp=7", lat); end
    checks++; if (k_count !== 16'd1) begin errors++; $display("FAIL sv_kcount got=%0d exp=1", k_count); end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      in_last = (v == 2);
      start = (v == 1);
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL si_stream got=%h exp=%h", obs, expv); end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 0; n < 15; n++) begin
      start = (n == 2 || n == 3);
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL si_run got=%h exp=%h", obs, expv); end
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL si_done_count got=%0d exp=1", dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL si_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (k_count !== 16'd3) begin errors++; $display("FAIL rm_kcount got=%0d exp=3", k_count); end
    rst = 1'b0;
    #1;
    model_reset();
    expv = model_obs();
    checks++; if (obs !== '0) begin errors++; $display("FAIL rm_async_zero got=%h exp=0", obs); end
    tick();
    rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL rm_after got=%h exp=%h", obs, expv); end
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rm_no_done got=%0d exp=0", dones); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_last = 1'b1;
    in_data = $urandom;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL rm_rerun got=%h exp=%h", obs, expv); end
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL rm_rerun_latency got=%0d exp=7", lat); end
    tick();
  endtask

  task automatic test_saturation();
    int lat = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int v = 0; v < 65537; v++) begin
      in_data = $urandom;
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL sat_stream v=%0d got=%h exp=%h", v, obs, expv); end
    end
    checks++; if (k_count !== 16'hFFFF) begin errors++; $display("FAIL sat_kcount got=%h exp=ffff", k_count); end
    in_data = $urandom;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL sat_flush got=%h exp=%h", obs, expv); end
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL sat_done_latency got=%0d exp=7", lat); end
    checks++; if (k_count !== 16'hFFFF) begin errors++; $display("FAIL sat_kcount_end got=%h exp=ffff", k_count); end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_job();
    test_bubble();
    test_single_vector();
    test_start_ignored();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 4: lane count, equal to systolic array rows.
REQ-002 SHALL have parameter DW, default 8: lane data width, matching the processing-element operand width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin-job pulse; honoured in IDLE only.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a vector.
REQ-007 SHALL have port in_ready, output, 1: feeder accepts a vector this cycle.
REQ-008 SHALL have port in_data, input, N*DW: lane i occupies bits [i*DW +: DW].
REQ-009 SHALL have port in_last, input, 1: the accepted vector is the final one of the job.
REQ-010 SHALL have port feed_data, output, N*DW: skewed lanes driven to the array west edge.
REQ-011 SHALL have port pe_clr, output, 1: active-high accumulator clear for the array.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse marking that all array results are final.
REQ-014 SHALL have port k_count, output, 16: number of vectors accepted in the current job.

Function
REQ-015 SHALL implement the states IDLE, CLR, STREAM, FLUSH and DONE.
REQ-016 SHALL move IDLE->CLR on start=1; CLR->STREAM after exactly 1 cycle; STREAM->FLUSH on an accepted vector with in_last=1; FLUSH->DONE after exactly 2N-1 cycles; DONE->IDLE after 1 cycle.
REQ-017 SHALL assert pe_clr only in CLR, and SHALL assert done only in DONE.
REQ-018 SHALL drive in_ready=1 only in STREAM; a vector is accepted when in_valid and in_ready are both high.
REQ-019 SHALL, for lane i, output on feed_data the lane-i value accepted at cycle t-1-i (lane 0 has 1 register stage, lane N-1 has N stages).
REQ-020 SHALL insert zero into every lane in any cycle with no accepted vector (bubble, CLR, FLUSH, DONE, IDLE), so bubbles keep lane alignment and add zero products.
REQ-021 SHALL clear k_count to 0 in CLR, increment it per accepted vector, and saturate it at 16'hFFFF.
REQ-022 SHALL ignore start outside IDLE, and SHALL ignore in_last when no vector is accepted.
REQ-023 SHALL treat a vector accepted with in_last in the first STREAM cycle as a valid single-vector job.
REQ-024 SHALL register feed_data and must not give it a combinational path from in_data.

Reset
REQ-025 SHALL, with rst low, immediately force the state to IDLE, all skew registers to 0, feed_data to 0, in_ready to 0, pe_clr to 0, busy to 0, done to 0 and k_count to 0.
REQ-026 SHALL, when reset arrives mid-job, abandon the job without a done pulse; the next job starts only on a new start.

Structure
REQ-027 SHALL take N, DW and the state encoding from the shared package systolic_pkg.
REQ-028 SHALL instantiate one sub-module, skew_delay (a parameterised depth-D, DW-wide shift register with async active-low reset), once per lane with D=i+1.

Verification (N=4, DW=8)
REQ-029 Single job: start, then vectors {1,2,3,4} and {5,6,7,8}(last) -> pe_clr high 1 cycle; lane0 shows 1,5 and lane3 shows 4,8 three cycles later; done 7 cycles after FLUSH entry; k_count=2.
REQ-030 Bubble: in_valid low for 2 cycles mid-stream -> all lanes show 0 in the matching skewed slots; with the block feeding a 4x4 PE array, results equal the golden matmul.
REQ-031 Single-vector job: {9,9,9,9} with in_last in the first STREAM cycle -> FLUSH follows immediately; done follows 7 FLUSH cycles later; k_count=1.
REQ-032 Reset mid-STREAM: rst low for 1 cycle after 3 vectors -> all outputs 0 at once, state IDLE, no done pulse; a following start runs a normal job.
REQ-033 Start ignored: start pulsed during FLUSH -> no effect; exactly one done pulse; state returns to IDLE.
REQ-034 Saturation: 65 537 vectors without last -> k_count holds 16'hFFFF, and feed_data keeps skewing correctly.
